// File: rtl/cdb_arb_mux.sv
// ============================================================================
// Module   : cdb_arb_mux
// Brief    : Registered N-way round-robin arbitrating mux for the CDB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arb_mux #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6,
    parameter int N     = 4,
    parameter int SRC_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N*TAG_W-1:0]   in_tag,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic [SRC_W-1:0]     out_src
);

    localparam logic [SRC_W:0]   C_N    = (SRC_W+1)'(N);
    localparam logic [SRC_W-1:0] C_LAST = SRC_W'(N-1);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [TAG_W-1:0] r_tag;
    logic [SRC_W-1:0] r_src;
    logic [SRC_W-1:0] r_ptr;

    logic [SRC_W-1:0] w_ptr_eff;
    logic [SRC_W:0]   w_cand;
    logic [N-1:0]     w_grant;
    logic [SRC_W-1:0] w_win;
    logic [SRC_W-1:0] w_ptr_next;
    logic             w_any;
    logic             w_load;

    // Unreachable pointer encodings collapse to channel 0.
    assign w_ptr_eff = (r_ptr > C_LAST) ? '0 : r_ptr;

    // Scan from the pointer, wrapping modulo N rather than modulo 2^SRC_W.
    always_comb begin
        w_grant = '0;
        w_win   = '0;
        w_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = {1'b0, w_ptr_eff} + (SRC_W+1)'(k);
            if (w_cand >= C_N) begin
                w_cand = w_cand - C_N;
            end
            if (!w_any && in_valid[w_cand[SRC_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_cand[SRC_W-1:0];
            end
        end
        if (w_any) begin
            w_grant[w_win] = 1'b1;
        end
    end

    // Reset also suppresses acceptance so a mid-transfer reset reports nothing.
    assign w_load     = resetn && (!r_valid || out_ready) && !flush;
    assign in_ready   = w_grant & {N{w_load}};
    assign w_ptr_next = (w_win == C_LAST) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= w_any;
            if (w_any) begin
                r_data <= in_data[w_win*WIDTH +: WIDTH];
                r_tag  <= in_tag[w_win*TAG_W +: TAG_W];
                r_src  <= w_win;
                r_ptr  <= w_ptr_next;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_tag   = r_tag;
    assign out_src   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arb_mux.sv
// ============================================================================
// Module   : tb_cdb_arb_mux
// Brief    : Directed self-checking bench for cdb_arb_mux (N=4 and N=3 builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arb_mux;

    logic         clk;
    logic         resetn;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [127:0] in_data;
    logic [23:0]  in_tag;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [5:0]   out_tag;
    logic [1:0]   out_src;

    logic         p_resetn;
    logic [2:0]   p_in_valid;
    logic [2:0]   p_in_ready;
    logic [23:0]  p_in_data;
    logic [11:0]  p_in_tag;
    logic         p_flush;
    logic         p_out_valid;
    logic         p_out_ready;
    logic [7:0]   p_out_data;
    logic [3:0]   p_out_tag;
    logic [1:0]   p_out_src;

    int checks;
    int errors;
    int acc [4];

    cdb_arb_mux dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_src   (out_src)
    );

    cdb_arb_mux #(.WIDTH(8), .TAG_W(4), .N(3)) dut_p (
        .clk       (clk),
        .resetn    (p_resetn),
        .in_valid  (p_in_valid),
        .in_ready  (p_in_ready),
        .in_data   (p_in_data),
        .in_tag    (p_in_tag),
        .flush     (p_flush),
        .out_valid (p_out_valid),
        .out_ready (p_out_ready),
        .out_data  (p_out_data),
        .out_tag   (p_out_tag),
        .out_src   (p_out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        resetn     = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        in_tag     = '0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        p_resetn   = 1'b0;
        p_in_valid = '0;
        p_in_data  = {8'hC2, 8'hB1, 8'hA0};
        p_in_tag   = {4'd3, 4'd2, 4'd1};
        p_flush    = 1'b0;
        p_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        tick();
        tick();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data,       32'd0);
        chk("rst_tag",   32'(out_tag),   32'd0);
        chk("rst_src",   32'(out_src),   32'd0);
        chk("rst_ptr",   32'(dut.r_ptr), 32'd0);
        chk("rst_ready", 32'(in_ready),  32'd0);

        // Single source: channel 2, tag 5, data DEADBEEF
        resetn    = 1'b1;
        in_valid  = 4'b0100;
        in_data   = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
        in_tag    = {6'd0, 6'd5, 6'd0, 6'd0};
        out_ready = 1'b1;
        #1;
        chk("single_ready", 32'(in_ready), 32'b0100);
        tick();
        in_valid = '0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_tag",   32'(out_tag),   32'd5);
        chk("single_data",  out_data,       32'hDEADBEEF);
        chk("single_src",   32'(out_src),   32'd2);
        chk("single_ptr",   32'(dut.r_ptr), 32'd3);
        tick();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold_data", out_data,   32'hDEADBEEF);

        // Fairness from reset
        resetn = 1'b0;
        tick();
        resetn   = 1'b1;
        in_valid = 4'hF;
        in_data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
        in_tag   = {6'd11, 6'd10, 6'd9, 6'd8};
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("fair_ready", 32'(in_ready), 32'(1 << (k % 4)));
            for (int i = 0; i < 4; i++) if (in_ready[i]) acc[i]++;
            tick();
            chk("fair_src", 32'(out_src), 32'(k % 4));
            chk("fair_tag", 32'(out_tag), 32'(8 + k % 4));
        end
        for (int i = 0; i < 4; i++) chk("fair_count", 32'(acc[i]), 32'd2);
        in_valid = '0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: channels 1 and 3, pointer at 0
        in_valid  = 4'b1010;
        out_ready = 1'b0;
        #1;
        chk("bp_first_ready", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_hold_ready", 32'(in_ready),  32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_src",   32'(out_src),   32'd1);
            chk("bp_hold_tag",   32'(out_tag),   32'd9);
            chk("bp_hold_data",  out_data,       32'h1000_0001);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b1000);
        tick();
        in_valid = '0;
        chk("bp_next_src",   32'(out_src),   32'd3);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        tick();

        // Flush with a held result and channel 0 requesting, pointer at 0
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        tick();
        chk("fl_pre_valid", 32'(out_valid), 32'd1);
        chk("fl_pre_ptr",   32'(dut.r_ptr), 32'd1);
        flush = 1'b1;
        #1;
        chk("fl_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ptr",   32'(dut.r_ptr), 32'd1);
        #1;
        chk("fl_after_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("fl_after_src",   32'(out_src),   32'd0);
        chk("fl_after_valid", 32'(out_valid), 32'd1);

        // Reset mid-operation with all channels requesting
        in_valid  = 4'hF;
        out_ready = 1'b1;
        resetn    = 1'b0;
        #1;
        chk("mrst_ready", 32'(in_ready), 32'd0);
        tick();
        resetn = 1'b1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data",  out_data,       32'd0);
        chk("mrst_tag",   32'(out_tag),   32'd0);
        chk("mrst_src",   32'(out_src),   32'd0);
        chk("mrst_ptr",   32'(dut.r_ptr), 32'd0);
        #1;
        chk("mrst_next_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("mrst_next_src", 32'(out_src), 32'd0);
        in_valid = '0;

        // N=3 build: sequence 0,1,2,0 and pointer stays below 3
        p_resetn    = 1'b1;
        p_in_valid  = 3'b111;
        p_out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("p3_ready", 32'(p_in_ready), 32'(1 << (k % 3)));
            tick();
            chk("p3_src",  32'(p_out_src),  32'(k % 3));
            chk("p3_data", 32'(p_out_data), 32'(8'hA0 + 8'(k % 3) * 8'h11));
            chk("p3_ptr",  32'(dut_p.r_ptr), 32'((k + 1) % 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdb_arb_mux.md
# cdb_arb_mux

Parametrised, registered N-way arbitrating multiplexer for the common data bus of the dynamic pipeline. Up to N functional-unit result channels present `{tag, data}` under a valid/ready handshake. One winner per cycle is chosen by round-robin and latched into a single output register, which drives the CDB broadcast. The block supersedes the fixed 4-way combinational select wherever several sources compete for one shared bus and need fairness and backpressure.

## Interface
- `WIDTH`, default 32: data width per channel.
- `TAG_W`, default 6: reservation-station / ROB tag width per channel.
- `N`, default 4: number of input channels; legal range 2..16.
- `SRC_W`, default `$clog2(N)`: width of the source-index output; derived, never overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `resetn` input 1: reset, synchronous and active-low.
- `in_valid` input N: bit i = channel i offers a result.
- `in_ready` output N: bit i = channel i's result is accepted this cycle.
- `in_data` input N*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_tag` input N*TAG_W: channel i occupies bits `[i*TAG_W +: TAG_W]`.
- `flush` input 1: pipeline squash; discards held and offered results.
- `out_valid` output 1: output register holds a result.
- `out_ready` input 1: the consumer takes the result this cycle.
- `out_data` output WIDTH: registered winning data.
- `out_tag` output TAG_W: registered winning tag.
- `out_src` output SRC_W: index of the winning channel.

## Operation
- State: output register `{out_valid, out_data, out_tag, out_src}` and round-robin pointer `ptr` (SRC_W bits, value 0..N-1).
- Priority order: `ptr`, `ptr+1`, …, wrapping modulo N (not modulo 2^SRC_W when N is not a power of two). The first channel with `in_valid` set wins and forms the one-hot `grant`.
- `load = (!out_valid || out_ready) && !flush`.
- `in_ready = grant & {N{load}}`. At most one bit is set. The bit is combinational from `in_valid`, `out_valid`, `out_ready` and `flush`.
- Producers must not make `in_valid` depend on `in_ready`. Once asserted, `in_valid` and its data/tag are held until accepted or flushed.
- On `load` with any `in_valid` set: register the winner's data, tag and index, set `out_valid=1`, and set `ptr = (winner+1) mod N`.
- On `load` with no `in_valid` set: `out_valid` goes to 0. Data, tag and src hold their old values. `ptr` is unchanged.
- When `out_valid && !out_ready && !flush`: the output register and `ptr` hold, and `in_ready` is all-zero.
- On `flush`: next cycle `out_valid=0`, `in_ready` is all-zero in the flush cycle, and `ptr` is unchanged. Flush has priority over `out_ready` and over every `in_valid`.
- Reset: `out_valid=0`, `out_data=0`, `out_tag=0`, `out_src=0`, `ptr=0`. Reset overrides `flush` and all handshakes. Asserting reset mid-transfer drops the held result with no acceptance reported.
- Unused pointer encodings (N < 2^SRC_W) are unreachable. If one is ever forced, the arbiter treats it as 0.

## Timing
- Latency: an input accepted in cycle t appears on `out_*` with `out_valid=1` in cycle t+1.
- Throughput: one result per cycle while `out_ready` stays 1. The output register is overwritten in the same edge in which its result is consumed.
- Outputs are stable while `out_valid=1 && out_ready=0`.
- Simultaneous requests: exactly one channel is accepted per cycle. A continuously requesting channel waits at most N-1 accepted transfers.
- Combinational path: `in_valid`/`out_ready`/`flush` → `in_ready`. There is no combinational path from inputs to `out_*`.

## Test plan
- Single source, N=4: channel 2 offers tag 5, data 0xDEADBEEF with `out_ready=1` → `in_ready=4'b0100` in that cycle. Next cycle `out_valid=1`, `out_tag=5`, `out_data=0xDEADBEEF`, `out_src=2`, and `ptr=3`.
- Fairness: all four channels hold `in_valid` for 8 cycles with `out_ready=1` from reset → `out_src` sequence 0,1,2,3,0,1,2,3 and each channel sees exactly 2 accepts.
- Backpressure: hold `out_ready=0` for 3 cycles while channels 1 and 3 request. The first accepted result is held unchanged with `in_ready=0` throughout. On release, the held result is consumed and the next winner follows the round-robin order.
- Flush: with `out_valid=1` and channel 0 requesting, assert `flush` for one cycle → `in_ready=0` in that cycle. Next cycle `out_valid=0` and `ptr` is unchanged. The next cycle then accepts channel 0.
- Reset mid-operation: drive `resetn=0` for one cycle while `out_valid=1` and all channels request → next cycle all `out_*` are 0 and `ptr=0`. The following accept goes to channel 0.
- Parametrisation: N=3, WIDTH=8, TAG_W=4 with all channels requesting → `out_src` sequence 0,1,2,0; the pointer never reaches 3.
